// File: rtl/fetch_stage_if.sv
// Fetch stage bus interface: redirect inputs from decode, the instruction
// memory request/response pair, and the outputs presented to the F/D register.
// The master modport is the fetch stage; the slave modport is its environment.
`timescale 1ns/1ps

interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             FETCH_EN;
    logic             FETCH_PCSrcD;
    logic [WIDTH-1:0] FETCH_PCBranchD;
    logic             FETCH_JumpD;
    logic [WIDTH-1:0] FETCH_PCJumpD;
    logic             FETCH_IMemReq;
    logic [WIDTH-1:0] FETCH_IMemAddr;
    logic [WIDTH-1:0] FETCH_IMemRdata;
    logic             FETCH_IMemValid;
    logic [WIDTH-1:0] FETCH_InstrF;
    logic [WIDTH-1:0] FETCH_PCPLUS4F;
    logic [WIDTH-1:0] FETCH_PCF;
    logic             FETCH_ValidF;
    logic             FETCH_MissStall;
    logic [31:0]      FETCH_StallCnt;
    logic [31:0]      FETCH_RedirCnt;

    modport master (
        input  FETCH_EN, FETCH_PCSrcD, FETCH_PCBranchD, FETCH_JumpD, FETCH_PCJumpD,
               FETCH_IMemRdata, FETCH_IMemValid,
        output FETCH_IMemReq, FETCH_IMemAddr, FETCH_InstrF, FETCH_PCPLUS4F,
               FETCH_PCF, FETCH_ValidF, FETCH_MissStall, FETCH_StallCnt, FETCH_RedirCnt
    );

    modport slave (
        output FETCH_EN, FETCH_PCSrcD, FETCH_PCBranchD, FETCH_JumpD, FETCH_PCJumpD,
               FETCH_IMemRdata, FETCH_IMemValid,
        input  FETCH_IMemReq, FETCH_IMemAddr, FETCH_InstrF, FETCH_PCPLUS4F,
               FETCH_PCF, FETCH_ValidF, FETCH_MissStall, FETCH_StallCnt, FETCH_RedirCnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage of the pipelined MIPS core. Owns the PC, issues one request at
// a time to a variable-latency instruction memory, buffers the returned word
// for the F/D register and applies branch/jump redirects from decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise the counter outputs are tied to zero.
`timescale 1ns/1ps

module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic          FETCH_CLK,
    input  logic          FETCH_RST,
    fetch_stage_if.master bus
);

    // S_DROP waits out a response whose address was abandoned by a redirect.
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instrBuf_q, instrBuf_d;

    logic             redirect;
    logic [WIDTH-1:0] redirTarget;
    logic [WIDTH-1:0] pcPlus4;
    logic             inHold;

    // A jump outranks a branch; neither takes effect while the pipe is stalled.
    assign redirect    = bus.FETCH_EN & (bus.FETCH_JumpD | bus.FETCH_PCSrcD);
    assign redirTarget = bus.FETCH_JumpD ? bus.FETCH_PCJumpD : bus.FETCH_PCBranchD;
    assign pcPlus4     = pc_q + WIDTH'(4);

    // Next-state, next-PC and buffer-capture decisions for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instrBuf_d = instrBuf_q;
        case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
                if (redirect) begin
                    pc_d    = redirTarget;
                    state_d = S_DROP;
                end
            end
            S_WAIT: begin
                if (bus.FETCH_IMemValid) begin
                    if (redirect) begin
                        pc_d    = redirTarget;
                        state_d = S_REQ;
                    end else begin
                        instrBuf_d = bus.FETCH_IMemRdata;
                        state_d    = S_HOLD;
                    end
                end else if (redirect) begin
                    pc_d    = redirTarget;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (bus.FETCH_EN) begin
                    pc_d    = redirect ? redirTarget : pcPlus4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = redirTarget;
                end
                if (bus.FETCH_IMemValid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State, PC and instruction buffer registers with synchronous reset.
    always_ff @(posedge FETCH_CLK) begin
        if (FETCH_RST) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instrBuf_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instrBuf_q <= instrBuf_d;
        end
    end

    // Outputs are forced to their idle values during the reset cycle itself.
    assign inHold               = (state_q == S_HOLD) & ~FETCH_RST;
    assign bus.FETCH_IMemReq    = (state_q == S_REQ) & ~FETCH_RST;
    assign bus.FETCH_IMemAddr   = pc_q;
    assign bus.FETCH_PCF        = pc_q;
    assign bus.FETCH_PCPLUS4F   = pcPlus4;
    assign bus.FETCH_ValidF     = inHold;
    assign bus.FETCH_MissStall  = ~inHold;
    assign bus.FETCH_InstrF     = inHold ? instrBuf_q : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCnt_q;
    logic [31:0] redirCnt_q;

    // Saturating counts of miss-stall cycles and accepted redirects.
    always_ff @(posedge FETCH_CLK) begin
        if (FETCH_RST) begin
            stallCnt_q <= '0;
            redirCnt_q <= '0;
        end else begin
            if ((state_q != S_HOLD) && (stallCnt_q != 32'hFFFF_FFFF)) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
            if (redirect && (redirCnt_q != 32'hFFFF_FFFF)) begin
                redirCnt_q <= redirCnt_q + 32'd1;
            end
        end
    end

    assign bus.FETCH_StallCnt = stallCnt_q;
    assign bus.FETCH_RedirCnt = redirCnt_q;
`else
    assign bus.FETCH_StallCnt = 32'd0;
    assign bus.FETCH_RedirCnt = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the pipelined MIPS core; directly upstream of the fetch-to-decode pipeline register.
- Owns the PC register and issues one-outstanding requests to a variable-latency instruction memory.
- Holds the returned word and presents FETCH_InstrF / FETCH_PCPLUS4F to the F/D register.
- Applies branch/jump redirects from decode and raises a miss-stall to the hazard unit while no instruction is ready.

Parameters:
- WIDTH, 32, data/address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- FETCH_CLK  in  1  clock, rising edge.
- FETCH_RST  in  1  synchronous active-high reset.
- FETCH_EN  in  1  advance enable from hazard unit (1 = F/D register loads this cycle).
- FETCH_PCSrcD  in  1  branch taken in decode.
- FETCH_PCBranchD  in  WIDTH  branch target.
- FETCH_JumpD  in  1  jump in decode.
- FETCH_PCJumpD  in  WIDTH  jump target.
- FETCH_IMemReq  out  1  request strobe, one cycle per request.
- FETCH_IMemAddr  out  WIDTH  request address (= PCF).
- FETCH_IMemRdata  in  WIDTH  returned instruction word.
- FETCH_IMemValid  in  1  Rdata valid; one-cycle pulse, latency >= 1 cycle after Req.
- FETCH_InstrF  out  WIDTH  instruction to F/D register.
- FETCH_PCPLUS4F  out  WIDTH  PCF+4 to F/D register.
- FETCH_PCF  out  WIDTH  current PC.
- FETCH_ValidF  out  1  FETCH_InstrF holds a real instruction.
- FETCH_MissStall  out  1  request to hazard unit to stall/clear F/D.
- FETCH_StallCnt  out  32  miss-stall cycle count (optional feature).
- FETCH_RedirCnt  out  32  accepted redirect count (optional feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. FETCH_RST sampled on rising FETCH_CLK and overrides everything else.
- Reset values: PCF=RESET_PC, instruction buffer=0, state=S_REQ, counters=0.
- Reset outputs: IMemReq=0 during the reset cycle, ValidF=0, MissStall=1, InstrF=0.
- Memory contract: instruction memory shares FETCH_RST and drops in-flight requests on reset.
- States: S_REQ, S_WAIT, S_HOLD, S_DROP.
- Redirect: redirect = FETCH_EN & (JumpD | PCSrcD). Target = PCJumpD if JumpD, else PCBranchD (jump wins). Redirects with FETCH_EN=0 are ignored.
- S_REQ:
  - IMemReq=1, IMemAddr=PCF for exactly one cycle.
  - Next state S_WAIT; S_DROP if redirect this cycle (PCF <= target).
- S_WAIT:
  - IMemReq=0.
  - IMemValid=1, no redirect: buffer <= Rdata, next S_HOLD.
  - IMemValid=1 with redirect: data discarded, PCF <= target, next S_REQ.
  - Redirect without IMemValid: PCF <= target, next S_DROP.
- S_HOLD:
  - ValidF=1, InstrF=buffer, MissStall=0.
  - EN=0: hold everything; outputs stable.
  - EN=1, no redirect: PCF <= PCF+4, next S_REQ.
  - EN=1 with redirect: PCF <= target, next S_REQ. The held word is loaded into F/D that edge; decode flushes it via F/D CLR.
- S_DROP:
  - Waits for the stale response. On IMemValid: discard, next S_REQ.
  - Further redirects update PCF and remain in S_DROP.
- All states other than S_HOLD: ValidF=0, InstrF=0 (NOP), MissStall=1.
- FETCH_PCPLUS4F = PCF+4, combinational, modulo 2^WIDTH (0xFFFFFFFC+4 -> 0x00000000). Sequential PC wraps the same way.
- IMemValid in S_REQ or S_HOLD is a protocol error: ignored, no state change.
- Throughput: with 1-cycle memory latency, one instruction every 3 cycles (REQ, WAIT, HOLD).
- Latency: Req to ValidF = memory latency + 1 cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - FETCH_StallCnt increments each non-reset cycle with MissStall=1.
  - FETCH_RedirCnt increments on each accepted redirect.
  - Both 32-bit, saturating at 0xFFFFFFFF, cleared by reset.
- Undefined: both ports remain present and are tied to 0; no counter flops.

Test Plan:
- Reset then 1-cycle memory returning 0x20080005 -> Req at PC 0x0 in cycle 1, ValidF=1 in cycle 3 with InstrF=0x20080005, PCPLUS4F=0x4; next Req at 0x4 after EN=1.
- FETCH_EN=0 for 5 cycles in S_HOLD -> PCF, InstrF, ValidF constant, no Req; EN=1 -> PCF=0x8, Req next cycle.
- Redirect PCSrcD=1, PCBranchD=0x40 in S_WAIT (memory latency 3) -> stale response discarded (ValidF stays 0), next Req at 0x40.
- JumpD=1 (PCJumpD=0x100) and PCSrcD=1 (PCBranchD=0x80) same cycle with EN=1 -> PCF=0x100.
- RESET_PC=0xFFFFFFFC -> PCPLUS4F=0x0; after consume, next Req at 0x0.
- FETCH_RST asserted while in S_WAIT -> next cycle PCF=RESET_PC, state S_REQ, counters=0 (with FETCH_PERF_CNT_EN).
